// File: rtl/counter_bus_master.sv
// counter_bus_master: range-checks one PLR/ULR/LLR/CCR request, writes the four counter registers over the ncs/nwr bus, pulses start_in, then waits for ec/err/timeout.
// Latency: range reject -> done on the 2nd cycle after cfg_valid; full run = CHECK + 4*(SETUP_CYC+WR_PULSE+1) [+ readback 4*(WR_PULSE+1)] + START_CYC + WAIT_END.
// Backpressure: cfg_ready is high only in IDLE; cfg_valid in any other state is ignored and nothing is queued.
//
// Ports:
//   clk_in, reset_in (async, active-low)
//   cfg_valid/cfg_ready + cfg_plr/ulr/llr/ccr    : request handshake and values
//   ncs, nwr, nrd, A0, A1, bus_dout, bus_oe      : counter register bus (strobes active-low)
//   bus_din                                      : read data, used only by the readback option
//   start_in, ctr_ec, ctr_err                    : counter start and end/error flags
//   busy, done, status                           : completion report (status held until next accept)
// Optional feature: define COUNTER_BUS_MASTER_READBACK_EN to read back and verify all four
// registers before start_in is pulsed.

module counter_bus_master #(
    parameter int          SETUP_CYC   = 1,
    parameter int          WR_PULSE    = 2,
    parameter int          START_CYC   = 2,
    parameter logic [15:0] RUN_TIMEOUT = 16'hFFFF
) (
    input  logic       clk_in,
    input  logic       reset_in,
    input  logic       cfg_valid,
    output logic       cfg_ready,
    input  logic [7:0] cfg_plr,
    input  logic [7:0] cfg_ulr,
    input  logic [7:0] cfg_llr,
    input  logic [7:0] cfg_ccr,
    output logic       ncs,
    output logic       nwr,
    output logic       nrd,
    output logic       A0,
    output logic       A1,
    output logic [7:0] bus_dout,
    output logic       bus_oe,
    input  logic [7:0] bus_din,
    output logic       start_in,
    input  logic       ctr_ec,
    input  logic       ctr_err,
    output logic       busy,
    output logic       done,
    output logic [1:0] status
);

    localparam logic [3:0] ST_IDLE    = 4'd0;
    localparam logic [3:0] ST_CHECK   = 4'd1;
    localparam logic [3:0] ST_SETUP   = 4'd2;
    localparam logic [3:0] ST_STROBE  = 4'd3;
    localparam logic [3:0] ST_HOLD    = 4'd4;
    localparam logic [3:0] ST_START   = 4'd5;
    localparam logic [3:0] ST_WAIT    = 4'd6;
`ifdef COUNTER_BUS_MASTER_READBACK_EN
    localparam logic [3:0] ST_RD_LOW  = 4'd7;
    localparam logic [3:0] ST_RD_HIGH = 4'd8;
`endif

    // Phase timers are loaded with (length-1) and leave their state when they reach zero.
    localparam logic [7:0] SETUP_LD = 8'(SETUP_CYC - 1);
    localparam logic [7:0] WR_LD    = 8'(WR_PULSE - 1);
    localparam logic [7:0] START_LD = 8'(START_CYC - 1);

    logic [3:0]  r_state;
    logic [1:0]  r_idx;
    logic [7:0]  r_tmr;
    logic [15:0] r_cyc;
    logic [7:0]  r_val [4];     // index order PLR, ULR, LLR, CCR == bus address
    logic [1:0]  r_status;
    logic        r_done;
    logic        r_cfg_ready;
    logic        r_ncs, r_nwr, r_nrd, r_a0, r_a1, r_oe, r_start, r_busy;
    logic [7:0]  r_dout;

    logic [3:0]  w_state_nxt;
    logic [1:0]  w_idx_nxt;
    logic [7:0]  w_tmr_nxt;
    logic [15:0] w_cyc_nxt;
    logic [15:0] w_cyc_inc;
    logic [1:0]  w_status_nxt;
    logic        w_done_nxt;
    logic        w_accept;
    logic        w_wr_phase;
    logic        w_rd_phase;
    logic        w_rd_low;

`ifdef COUNTER_BUS_MASTER_READBACK_EN
    logic        r_mis;
    logic        w_mis_nxt;
`else
    logic        w_unused_din;
    assign w_unused_din = ^bus_din;
`endif

    // Saturating so a disabled timeout can never wrap into a false match.
    assign w_cyc_inc = (r_cyc == 16'hFFFF) ? r_cyc : r_cyc + 16'd1;

    always_comb begin
        w_state_nxt  = r_state;
        w_idx_nxt    = r_idx;
        w_tmr_nxt    = (r_tmr == 8'd0) ? 8'd0 : r_tmr - 8'd1;
        w_cyc_nxt    = r_cyc;
        w_status_nxt = r_status;
        w_done_nxt   = 1'b0;
        w_accept     = 1'b0;
`ifdef COUNTER_BUS_MASTER_READBACK_EN
        w_mis_nxt    = r_mis;
`endif
        case (r_state)
            ST_IDLE: begin
                if (cfg_valid && r_cfg_ready) begin
                    w_accept     = 1'b1;
                    w_status_nxt = 2'b00;
                    w_state_nxt  = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if ((r_val[2] <= r_val[0]) && (r_val[0] <= r_val[1])) begin
                    w_state_nxt = ST_SETUP;
                    w_idx_nxt   = 2'd0;
                    w_tmr_nxt   = SETUP_LD;
                end else begin
                    w_status_nxt = 2'b01;
                    w_done_nxt   = 1'b1;
                    w_state_nxt  = ST_IDLE;
                end
            end
            ST_SETUP: begin
                if (r_tmr == 8'd0) begin
                    w_state_nxt = ST_STROBE;
                    w_tmr_nxt   = WR_LD;
                end
            end
            ST_STROBE: begin
                if (r_tmr == 8'd0) begin
                    w_state_nxt = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (r_idx != 2'd3) begin
                    w_idx_nxt   = r_idx + 2'd1;
                    w_state_nxt = ST_SETUP;
                    w_tmr_nxt   = SETUP_LD;
                end else begin
`ifdef COUNTER_BUS_MASTER_READBACK_EN
                    w_idx_nxt   = 2'd0;
                    w_mis_nxt   = 1'b0;
                    w_state_nxt = ST_RD_LOW;
                    w_tmr_nxt   = WR_LD;
`else
                    w_state_nxt = ST_START;
                    w_tmr_nxt   = START_LD;
`endif
                end
            end
`ifdef COUNTER_BUS_MASTER_READBACK_EN
            ST_RD_LOW: begin
                // Sample on the edge that ends the last nrd-low cycle.
                if (r_tmr == 8'd0) begin
                    if (bus_din != r_val[r_idx]) begin
                        w_mis_nxt = 1'b1;
                    end
                    w_state_nxt = ST_RD_HIGH;
                end
            end
            ST_RD_HIGH: begin
                if (r_idx != 2'd3) begin
                    w_idx_nxt   = r_idx + 2'd1;
                    w_state_nxt = ST_RD_LOW;
                    w_tmr_nxt   = WR_LD;
                end else if (r_mis) begin
                    w_status_nxt = 2'b10;
                    w_done_nxt   = 1'b1;
                    w_state_nxt  = ST_IDLE;
                end else begin
                    w_state_nxt = ST_START;
                    w_tmr_nxt   = START_LD;
                end
            end
`endif
            ST_START: begin
                if (r_tmr == 8'd0) begin
                    w_state_nxt = ST_WAIT;
                    w_cyc_nxt   = 16'd0;
                end
            end
            ST_WAIT: begin
                // err beats ec, and either beats a timeout landing on the same cycle.
                if (ctr_err) begin
                    w_status_nxt = 2'b01;
                    w_done_nxt   = 1'b1;
                    w_state_nxt  = ST_IDLE;
                end else if (ctr_ec) begin
                    w_status_nxt = 2'b00;
                    w_done_nxt   = 1'b1;
                    w_state_nxt  = ST_IDLE;
                end else if ((RUN_TIMEOUT != 16'd0) && (w_cyc_inc == RUN_TIMEOUT)) begin
                    w_status_nxt = 2'b11;
                    w_done_nxt   = 1'b1;
                    w_state_nxt  = ST_IDLE;
                end else begin
                    w_cyc_nxt = w_cyc_inc;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with the state they describe.
    always_comb begin
        w_wr_phase = (w_state_nxt == ST_SETUP) || (w_state_nxt == ST_STROBE) ||
                     (w_state_nxt == ST_HOLD);
`ifdef COUNTER_BUS_MASTER_READBACK_EN
        w_rd_low   = (w_state_nxt == ST_RD_LOW);
        w_rd_phase = w_rd_low || (w_state_nxt == ST_RD_HIGH);
`else
        w_rd_low   = 1'b0;
        w_rd_phase = 1'b0;
`endif
    end

    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            r_state     <= ST_IDLE;
            r_idx       <= 2'd0;
            r_tmr       <= 8'd0;
            r_cyc       <= 16'd0;
            for (int i = 0; i < 4; i++) r_val[i] <= 8'd0;
            r_status    <= 2'b00;
            r_done      <= 1'b0;
            r_cfg_ready <= 1'b1;
            r_ncs       <= 1'b1;
            r_nwr       <= 1'b1;
            r_nrd       <= 1'b1;
            r_a0        <= 1'b0;
            r_a1        <= 1'b0;
            r_oe        <= 1'b0;
            r_dout      <= 8'd0;
            r_start     <= 1'b0;
            r_busy      <= 1'b0;
`ifdef COUNTER_BUS_MASTER_READBACK_EN
            r_mis       <= 1'b0;
`endif
        end else begin
            r_state     <= w_state_nxt;
            r_idx       <= w_idx_nxt;
            r_tmr       <= w_tmr_nxt;
            r_cyc       <= w_cyc_nxt;
            if (w_accept) begin
                r_val[0] <= cfg_plr;
                r_val[1] <= cfg_ulr;
                r_val[2] <= cfg_llr;
                r_val[3] <= cfg_ccr;
            end
            r_status    <= w_status_nxt;
            r_done      <= w_done_nxt;
            r_cfg_ready <= (w_state_nxt == ST_IDLE);
            r_busy      <= (w_state_nxt != ST_IDLE);
            r_ncs       <= !(w_wr_phase || w_rd_phase);
            r_nwr       <= (w_state_nxt != ST_STROBE);
            r_nrd       <= !w_rd_low;
            r_oe        <= w_wr_phase;
            r_a0        <= (w_wr_phase || w_rd_phase) ? w_idx_nxt[1] : 1'b0;
            r_a1        <= (w_wr_phase || w_rd_phase) ? w_idx_nxt[0] : 1'b0;
            r_dout      <= w_wr_phase ? r_val[w_idx_nxt] : 8'd0;
            r_start     <= (w_state_nxt == ST_START);
`ifdef COUNTER_BUS_MASTER_READBACK_EN
            r_mis       <= w_mis_nxt;
`endif
        end
    end

    assign cfg_ready = r_cfg_ready;
    assign ncs       = r_ncs;
    assign nwr       = r_nwr;
    assign nrd       = r_nrd;
    assign A0        = r_a0;
    assign A1        = r_a1;
    assign bus_dout  = r_dout;
    assign bus_oe    = r_oe;
    assign start_in  = r_start;
    assign busy      = r_busy;
    assign done      = r_done;
    assign status    = r_status;

endmodule

// File: tb/tb_counter_bus_master.sv
// tb_counter_bus_master: randomized and directed requests against a cycle-level expectation of the register-bus sequence.
// Latency: N/A (bench).
// Backpressure: N/A (bench).

module tb_counter_bus_master;

    localparam int          SETUP_CYC   = 1;
    localparam int          WR_PULSE    = 2;
    localparam int          START_CYC   = 2;
    localparam logic [15:0] RUN_TIMEOUT = 16'd8;

    logic       clk_in = 1'b0;
    logic       reset_in;
    logic       cfg_valid;
    logic       cfg_ready;
    logic [7:0] cfg_plr, cfg_ulr, cfg_llr, cfg_ccr;
    logic       ncs, nwr, nrd, A0, A1;
    logic [7:0] bus_dout;
    logic       bus_oe;
    logic [7:0] bus_din;
    logic       start_in;
    logic       ctr_ec, ctr_err;
    logic       busy, done;
    logic [1:0] status;

    int errors = 0;
    int checks = 0;

    // Bus observer: register image built from writes, plus activity counters.
    logic [7:0] mem [4];
    logic       corrupt_ulr = 1'b0;
    int         ncs_low_cnt = 0;
    int         start_cnt   = 0;
    int         viol_cnt    = 0;

    always #5 clk_in = ~clk_in;

    counter_bus_master #(
        .SETUP_CYC  (SETUP_CYC),
        .WR_PULSE   (WR_PULSE),
        .START_CYC  (START_CYC),
        .RUN_TIMEOUT(RUN_TIMEOUT)
    ) dut (
        .clk_in   (clk_in),
        .reset_in (reset_in),
        .cfg_valid(cfg_valid),
        .cfg_ready(cfg_ready),
        .cfg_plr  (cfg_plr),
        .cfg_ulr  (cfg_ulr),
        .cfg_llr  (cfg_llr),
        .cfg_ccr  (cfg_ccr),
        .ncs      (ncs),
        .nwr      (nwr),
        .nrd      (nrd),
        .A0       (A0),
        .A1       (A1),
        .bus_dout (bus_dout),
        .bus_oe   (bus_oe),
        .bus_din  (bus_din),
        .start_in (start_in),
        .ctr_ec   (ctr_ec),
        .ctr_err  (ctr_err),
        .busy     (busy),
        .done     (done),
        .status   (status)
    );

    // Read model of the counter: returns what was written, optionally ULR+1.
    assign bus_din = !nrd ? ((corrupt_ulr && {A0, A1} == 2'b01) ? mem[1] + 8'd1 : mem[{A0, A1}])
                          : 8'h00;

    always @(negedge clk_in) begin
        if (!ncs) ncs_low_cnt++;
        if (start_in) start_cnt++;
        if ((!nwr && !nrd) || (!nrd && bus_oe) || (!ncs && start_in)) viol_cnt++;
        if (!nwr) mem[{A0, A1}] = bus_dout;
    end

    // ---------------------------------------------------------------- helpers
    task automatic check_writes(input logic [3:0][7:0] v);
        logic exp_nwr;
        @(negedge clk_in);
        for (int w = 0; w < 4; w++) begin
            for (int c = 0; c < SETUP_CYC + WR_PULSE + 1; c++) begin
                exp_nwr = !(c >= SETUP_CYC && c < SETUP_CYC + WR_PULSE);
                checks++;
                if ({ncs, nwr, nrd, bus_oe, A0, A1, bus_dout} !==
                    {1'b0, exp_nwr, 1'b1, 1'b1, 2'(w), v[w]}) begin
                    errors++;
                    $display("FAIL write%0d_cyc%0d: got ncs=%b nwr=%b nrd=%b oe=%b addr=%b%b dout=%0d, need ncs=0 nwr=%b nrd=1 oe=1 addr=%02b dout=%0d",
                             w, c, ncs, nwr, nrd, bus_oe, A0, A1, bus_dout, exp_nwr, 2'(w), v[w]);
                end
                @(negedge clk_in);
            end
        end
    endtask

`ifdef COUNTER_BUS_MASTER_READBACK_EN
    task automatic check_readback();
        logic exp_nrd;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < WR_PULSE + 1; c++) begin
                exp_nrd = (c == WR_PULSE);
                checks++;
                if ({ncs, nwr, nrd, bus_oe, A0, A1} !== {1'b0, 1'b1, exp_nrd, 1'b0, 2'(r)}) begin
                    errors++;
                    $display("FAIL read%0d_cyc%0d: got ncs=%b nwr=%b nrd=%b oe=%b addr=%b%b, need 0 1 %b 0 %02b",
                             r, c, ncs, nwr, nrd, bus_oe, A0, A1, exp_nrd, 2'(r));
                end
                @(negedge clk_in);
            end
        end
    endtask
`endif

    task automatic check_start();
        for (int c = 0; c < START_CYC; c++) begin
            checks++;
            if ({start_in, ncs, busy, done} !== 4'b1110) begin
                errors++;
                $display("FAIL start_cyc%0d: got start=%b ncs=%b busy=%b done=%b, need 1 1 1 0",
                         c, start_in, ncs, busy, done);
            end
            @(negedge clk_in);
        end
        checks++;
        if ({start_in, ncs, done} !== 3'b010) begin
            errors++;
            $display("FAIL wait_entry: got start=%b ncs=%b done=%b, need 0 1 0", start_in, ncs, done);
        end
    endtask

    // mode: 0 ec, 1 err, 2 both, 3 silent. d = WAIT_END cycle on which the flags rise.
    task automatic finish_wait(input int mode, input int d);
        int         exp_at, got_at;
        logic [1:0] exp_st;
        exp_at = (mode == 3) ? int'(RUN_TIMEOUT) : d + 1;
        exp_st = (mode == 3) ? 2'b11 : (mode == 0) ? 2'b00 : 2'b01;
        got_at = 0;
        for (int i = 0; i < 20 && got_at == 0; i++) begin
            if (i == d && mode != 3) begin
                ctr_ec  = (mode != 1);
                ctr_err = (mode != 0);
            end
            @(negedge clk_in);
            if (done) got_at = i + 1;
        end
        ctr_ec  = 1'b0;
        ctr_err = 1'b0;
        checks++;
        if (got_at != exp_at) begin
            errors++;
            $display("FAIL done_time mode%0d d%0d: got %0d cycles, need %0d", mode, d, got_at, exp_at);
        end
        checks++;
        if ({status, cfg_ready, busy} !== {exp_st, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL wait_status mode%0d: got status=%b ready=%b busy=%b, need %b 1 0",
                     mode, status, cfg_ready, busy, exp_st);
        end
    endtask

    // Issues one request at the current negedge and follows it to its done pulse.
    task automatic run_request(input logic [7:0] plr, input logic [7:0] ulr, input logic [7:0] llr,
                               input logic [7:0] ccr, input int mode, input int d, input bit hold);
        logic [3:0][7:0] v;
        bit              legal;
        int              ncs0;
        v     = {ccr, llr, ulr, plr};
        legal = (llr <= plr) && (plr <= ulr);
        ncs0  = ncs_low_cnt;
        cfg_plr = plr; cfg_ulr = ulr; cfg_llr = llr; cfg_ccr = ccr;
        cfg_valid = 1'b1;
        @(negedge clk_in);
        checks++;
        if ({busy, cfg_ready, done, ncs} !== 4'b1001) begin
            errors++;
            $display("FAIL accept: got busy=%b ready=%b done=%b ncs=%b, need 1 0 0 1", busy, cfg_ready, done, ncs);
        end
        if (hold) begin
            // Ignored while busy: these must never reach the bus.
            cfg_plr = ~plr; cfg_ulr = ~ulr; cfg_llr = ~llr; cfg_ccr = ~ccr;
        end else begin
            cfg_valid = 1'b0;
        end
        if (!legal) begin
            @(negedge clk_in);
            checks++;
            if ({done, status, cfg_ready} !== 4'b1011 || ncs_low_cnt != ncs0) begin
                errors++;
                $display("FAIL range_err p%0d u%0d l%0d: got done=%b status=%b ready=%b ncs_low=%0d, need 1 01 1 0",
                         plr, ulr, llr, done, status, cfg_ready, ncs_low_cnt - ncs0);
            end
        end else begin
            check_writes(v);
`ifdef COUNTER_BUS_MASTER_READBACK_EN
            check_readback();
`endif
            check_start();
            finish_wait(mode, d);
        end
        cfg_valid = 1'b0;
    endtask

    // ---------------------------------------------------------------- scenarios
    task automatic test_reset();
        reset_in = 1'b0;
        repeat (2) @(negedge clk_in);
        checks++;
        if ({ncs, nwr, nrd, A0, A1, bus_dout, bus_oe, start_in, busy, done, status, cfg_ready} !==
            {5'b11100, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1}) begin
            errors++;
            $display("FAIL reset_vals: got ncs=%b nwr=%b nrd=%b a=%b%b dout=%0d oe=%b start=%b busy=%b done=%b st=%b ready=%b",
                     ncs, nwr, nrd, A0, A1, bus_dout, bus_oe, start_in, busy, done, status, cfg_ready);
        end
        reset_in = 1'b1;
        @(negedge clk_in);
    endtask

    task automatic test_range_error();
        run_request(8'd5, 8'd200, 8'd10, 8'd1, 0, 0, 1'b0);
        run_request(8'd31, 8'd30, 8'd10, 8'd1, 0, 0, 1'b0);   // plr one above ulr
        run_request(8'd9, 8'd30, 8'd10, 8'd1, 0, 0, 1'b0);    // plr one below llr
    endtask

    task automatic test_nominal();
        run_request(8'd20, 8'd30, 8'd10, 8'd2, 0, 2, 1'b0);
        @(negedge clk_in);
        checks++;
        if ({done, status, cfg_ready} !== 4'b0001) begin
            errors++;
            $display("FAIL done_pulse: got done=%b status=%b ready=%b, need 0 00 1", done, status, cfg_ready);
        end
        run_request(8'd77, 8'd77, 8'd77, 8'd0, 0, 0, 1'b0);   // degenerate range, ccr=0
    endtask

    task automatic test_flag_priority();
        run_request(8'd20, 8'd30, 8'd10, 8'd2, 2, 3, 1'b0);   // both flags -> err
        run_request(8'd0, 8'd255, 8'd0, 8'd9, 1, 0, 1'b0);    // err on first WAIT cycle
        run_request(8'd50, 8'd60, 8'd40, 8'd3, 0, 7, 1'b0);   // ec on the timeout cycle
    endtask

    task automatic test_timeout();
        run_request(8'd20, 8'd30, 8'd10, 8'd2, 3, 0, 1'b0);
    endtask

    task automatic test_back_to_back();
        // Each request starts on the done cycle of the previous; cfg_valid stays high while busy.
        run_request(8'd100, 8'd200, 8'd50, 8'd7, 0, 1, 1'b1);
        run_request(8'd3, 8'd4, 8'd5, 8'd6, 0, 0, 1'b1);
        run_request(8'd128, 8'd255, 8'd0, 8'd0, 1, 4, 1'b1);
    endtask

    task automatic test_random();
        logic [7:0] l, u, p;
        for (int n = 0; n < 30; n++) begin
            l = 8'($urandom_range(0, 255));
            u = 8'($urandom_range(int'(l), 255));
            p = ($urandom_range(0, 9) < 7) ? 8'($urandom_range(int'(l), int'(u))) : 8'($urandom_range(0, 255));
            run_request(p, u, l, ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom),
                        int'($urandom_range(0, 3)), int'($urandom_range(0, 7)), 1'($urandom));
            repeat ($urandom_range(0, 2)) @(negedge clk_in);
        end
    endtask

    task automatic test_reset_mid_write();
        cfg_plr = 8'd20; cfg_ulr = 8'd30; cfg_llr = 8'd10; cfg_ccr = 8'd2;
        cfg_valid = 1'b1;
        @(negedge clk_in);
        cfg_valid = 1'b0;
        repeat (1 + SETUP_CYC) @(negedge clk_in);
        checks++;
        if ({ncs, nwr, bus_oe} !== 3'b001) begin
            errors++;
            $display("FAIL pre_reset_strobe: got ncs=%b nwr=%b oe=%b, need 0 0 1", ncs, nwr, bus_oe);
        end
        #2 reset_in = 1'b0;
        #1;
        checks++;
        if ({ncs, nwr, bus_oe} !== 3'b110) begin
            errors++;
            $display("FAIL async_reset: got ncs=%b nwr=%b oe=%b, need 1 1 0", ncs, nwr, bus_oe);
        end
        @(negedge clk_in);
        reset_in = 1'b1;
        @(negedge clk_in);
        checks++;
        if ({cfg_ready, status, busy} !== 4'b1000) begin
            errors++;
            $display("FAIL post_reset: got ready=%b status=%b busy=%b, need 1 00 0", cfg_ready, status, busy);
        end
    endtask

`ifdef COUNTER_BUS_MASTER_READBACK_EN
    task automatic test_readback_mismatch();
        int start0, got;
        start0 = start_cnt;
        corrupt_ulr = 1'b1;
        cfg_plr = 8'd20; cfg_ulr = 8'd30; cfg_llr = 8'd10; cfg_ccr = 8'd2;
        cfg_valid = 1'b1;
        @(negedge clk_in);
        cfg_valid = 1'b0;
        got = 0;
        for (int i = 0; i < 60 && got == 0; i++) begin
            @(negedge clk_in);
            if (done) got = 1;
        end
        corrupt_ulr = 1'b0;
        checks++;
        if (got != 1 || status !== 2'b10 || start_cnt != start0) begin
            errors++;
            $display("FAIL readback_mismatch: got done_seen=%0d status=%b start_cycles=%0d, need 1 10 0",
                     got, status, start_cnt - start0);
        end
    endtask
`endif

    task automatic test_bus_rules();
        checks++;
        if (viol_cnt != 0) begin
            errors++;
            $display("FAIL bus_rules: got %0d violating cycles, need 0", viol_cnt);
        end
    endtask

    initial begin
        cfg_valid = 1'b0;
        cfg_plr = 8'd0; cfg_ulr = 8'd0; cfg_llr = 8'd0; cfg_ccr = 8'd0;
        ctr_ec = 1'b0; ctr_err = 1'b0;
        test_reset();
        test_range_error();
        test_nominal();
        test_flag_priority();
        test_timeout();
        test_back_to_back();
        test_random();
        test_reset_mid_write();
`ifdef COUNTER_BUS_MASTER_READBACK_EN
        test_readback_mismatch();
`endif
        test_bus_rules();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
